skinny_round_ctrl: RTL and testbench
====================================

Name: skinny_round_ctrl

Overview:
- Control sequencer for the second-order masked SKINNY-64-64 encryption core (NullFresh, 3 shares).
- Drives the select and enable lines of the core's mux-input state/key flip-flops (sel=1 loads fresh shares, sel=0 takes round feedback).
- Steps the multi-stage masked S-box pipeline, generates the 6-bit round constant and flags round boundaries.
- Runs a start/done handshake toward the host wrapper.

Parameters:
- ROUNDS, 32, number of SKINNY rounds per encryption (2..63).
- STAGES, 4, clock cycles per round (masked S-box pipeline depth); must be >= 1.
- RCW, 6, round-constant width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new encryption; sampled only in IDLE.
- done_ack  input  1  host acknowledges the result; sampled only in DONE.
- busy  output  1  high in LOAD and RUN.
- done  output  1  ciphertext shares valid; high throughout DONE.
- sel_load  output  1  select for the state/key mux-FFs; 1 = plaintext/key shares, 0 = feedback.
- en_state  output  1  clock-enable for the state/key registers.
- stage  output  clog2(STAGES) (minimum 1)  current pipeline stage within the round.
- round_end  output  1  high on the last stage cycle of each round.
- last_round  output  1  high during the whole final round.
- round_cnt  output  6  current round number, 1..ROUNDS; 0 outside RUN.
- rc  output  RCW  round constant for the current round.

Behaviour:
- Reset values (async, all registers): state=IDLE, busy=0, done=0, sel_load=0, en_state=0, stage=0, round_end=0, last_round=0, round_cnt=0, rc=0.
- Outputs are registered/Moore. The only combinational decode allowed is from FSM state and counters.
- IDLE:
  - start=1 -> LOAD. Otherwise stay.
- LOAD (exactly 1 cycle):
  - sel_load=1, en_state=1, busy=1.
  - Next edge -> RUN with round_cnt=1, stage=0, rc=0x01.
- RUN:
  - sel_load=0, busy=1.
  - en_state=1 only when round_end=1, i.e. the state register updates once per round. Pipeline registers inside the S-box are free-running.
  - stage counts 0..STAGES-1 and wraps to 0. round_end = (stage==STAGES-1).
  - On each round_end edge with round_cnt<ROUNDS: round_cnt+1 and rc advances.
  - On the round_end edge with round_cnt==ROUNDS -> DONE; round_cnt, stage and rc clear to 0.
  - last_round = (round_cnt==ROUNDS).
- rc LFSR update: rc_next = {rc[4:0], rc[5]^rc[4]^1}.
  - Starting from 0, the sequence is 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3E, 0x3D, 0x3B, 0x37, 0x2F, ...
  - Round 32 uses 0x38.
- DONE:
  - done=1, busy=0, en_state=0.
  - Stays until done_ack=1, then -> IDLE. start is ignored in DONE.
- Latency: the start accepted at edge E0 gives done=1 from edge E0+1+ROUNDS*STAGES. Default: 129 cycles.
- start is ignored while busy (no queueing, no restart).
- done_ack is ignored outside DONE.
- start and done_ack both high in DONE: the ack is taken, the FSM goes to IDLE, and start must be re-asserted.
- STAGES=1: round_end is constantly 1 in RUN and stage stays 0.
- rst asserted mid-operation: immediate return to reset values. No partial result is flagged. The state registers are left to the datapath, and the next LOAD overwrites them.
- Illegal FSM encodings recover to IDLE on the next edge.

Test Plan:
- Reset with start=1 held: all outputs 0 while rst=1. After release, start is accepted and sel_load=1 for exactly one cycle.
- Nominal run (ROUNDS=32, STAGES=4):
  - busy high for 129 cycles; done rises at E0+129.
  - en_state pulses 1 (LOAD) plus 32 (round ends).
  - rc trace 01,03,07,0F,1F,3E,...,38.
  - round_cnt 1..32; last_round high for 4 cycles.
- start pulsed at cycles 10 and 60 of a run: ignored, and the done time is unchanged.
- DONE held for 20 cycles without done_ack: done stays 1 and en_state stays 0. done_ack=1 together with start=1 -> IDLE; a second start one cycle later begins a new run with rc=0x01.
- rst asserted in round 17, stage 2: outputs clear asynchronously before the next edge. A fresh run then completes in 129 cycles with the correct rc sequence.
- STAGES=1, ROUNDS=2: LOAD, RUN for 2 cycles (rc 01, 03, round_end=1 both), done at E0+3.

Source files
------------

// File: rtl/skinny_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : skinny_round_ctrl
// Purpose  : Control sequencer for a masked SKINNY-64-64 core (3 shares).
//            Loads fresh shares, steps the multi-cycle masked S-box pipeline,
//            produces the round constant, flags round boundaries and runs a
//            start/done handshake toward the host.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            start_i      - start a new encryption (sampled in IDLE only)
//            done_ack_i   - host acknowledges result (sampled in DONE only)
//            busy_o       - high in LOAD and RUN
//            done_o       - ciphertext shares valid, high throughout DONE
//            sel_load_o   - state/key mux select: 1 = fresh shares, 0 = feedback
//            en_state_o   - state/key register enable
//            stage_o      - pipeline stage within the current round
//            round_end_o  - last stage cycle of a round
//            last_round_o - high during the whole final round
//            round_cnt_o  - round number 1..ROUNDS, 0 outside RUN
//            rc_o         - round constant for the current round
// Revision : 1.0 - initial release
// ============================================================================
module skinny_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int STAGES = 4,
    parameter int RCW    = 6,
    localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           done_ack_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           sel_load_o,
    output logic           en_state_o,
    output logic [SW-1:0]  stage_o,
    output logic           round_end_o,
    output logic           last_round_o,
    output logic [5:0]     round_cnt_o,
    output logic [RCW-1:0] rc_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
    localparam logic [5:0]    LAST_ROUND = 6'(ROUNDS);
    // A single-stage pipeline ends a round on every RUN cycle.
    localparam logic          SINGLE_STG = (STAGES == 1);

    state_t         state_q;
    logic           busy_q;
    logic           done_q;
    logic           sel_load_q;
    logic           en_state_q;
    logic [SW-1:0]  stage_q;
    logic           round_end_q;
    logic           last_round_q;
    logic [5:0]     round_cnt_q;
    logic [RCW-1:0] rc_q;

    logic [RCW-1:0] rc_d;
    logic [5:0]     round_cnt_d;
    logic [SW-1:0]  stage_d;

    // Round-constant LFSR; the constant-1 feedback term makes the all-zero
    // reset value a valid seed, so the first round gets 0x01.
    assign rc_d        = {rc_q[RCW-2:0], rc_q[RCW-1] ^ rc_q[RCW-2] ^ 1'b1};
    assign round_cnt_d = round_cnt_q + 6'd1;
    assign stage_d     = stage_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sel_load_q   <= 1'b0;
            en_state_q   <= 1'b0;
            stage_q      <= '0;
            round_end_q  <= 1'b0;
            last_round_q <= 1'b0;
            round_cnt_q  <= '0;
            rc_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                        sel_load_q <= 1'b1;
                        en_state_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q      <= S_RUN;
                    sel_load_q   <= 1'b0;
                    stage_q      <= '0;
                    round_cnt_q  <= 6'd1;
                    rc_q         <= rc_d;
                    round_end_q  <= SINGLE_STG;
                    en_state_q   <= SINGLE_STG;
                    last_round_q <= (LAST_ROUND == 6'd1);
                end
                S_RUN: begin
                    if (round_end_q) begin
                        if (round_cnt_q == LAST_ROUND) begin
                            state_q      <= S_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            en_state_q   <= 1'b0;
                            round_end_q  <= 1'b0;
                            last_round_q <= 1'b0;
                            stage_q      <= '0;
                            round_cnt_q  <= '0;
                            rc_q         <= '0;
                        end else begin
                            stage_q      <= '0;
                            round_cnt_q  <= round_cnt_d;
                            rc_q         <= rc_d;
                            round_end_q  <= SINGLE_STG;
                            en_state_q   <= SINGLE_STG;
                            last_round_q <= (round_cnt_d == LAST_ROUND);
                        end
                    end else begin
                        // The state register only captures at the round end.
                        stage_q     <= stage_d;
                        round_end_q <= (stage_d == LAST_STAGE);
                        en_state_q  <= (stage_d == LAST_STAGE);
                    end
                end
                S_DONE: begin
                    if (done_ack_i) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    sel_load_q   <= 1'b0;
                    en_state_q   <= 1'b0;
                    stage_q      <= '0;
                    round_end_q  <= 1'b0;
                    last_round_q <= 1'b0;
                    round_cnt_q  <= '0;
                    rc_q         <= '0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sel_load_o   = sel_load_q;
    assign en_state_o   = en_state_q;
    assign stage_o      = stage_q;
    assign round_end_o  = round_end_q;
    assign last_round_o = last_round_q;
    assign round_cnt_o  = round_cnt_q;
    assign rc_o         = rc_q;

endmodule
`default_nettype wire

// File: tb/tb_skinny_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_skinny_round_ctrl
// Purpose  : Scoreboard bench for skinny_round_ctrl. A nominal instance
//            (32 rounds, 4 stages) and a minimal one (2 rounds, 1 stage).
// Revision : 1.0 - initial release
// ============================================================================
module tb_skinny_round_ctrl;

    localparam int R = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, ack = 1'b0;
    logic start2 = 1'b0, ack2 = 1'b0;

    logic       busy, done, sel_load, en_state, round_end, last_round;
    logic [1:0] stage;
    logic [5:0] round_cnt, rc;

    logic       busy2, done2, sel_load2, en_state2, round_end2, last_round2;
    logic [0:0] stage2;
    logic [5:0] round_cnt2, rc2;

    skinny_round_ctrl #(.ROUNDS(R), .STAGES(S), .RCW(6)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .done_ack_i(ack),
        .busy_o(busy), .done_o(done), .sel_load_o(sel_load),
        .en_state_o(en_state), .stage_o(stage), .round_end_o(round_end),
        .last_round_o(last_round), .round_cnt_o(round_cnt), .rc_o(rc)
    );

    skinny_round_ctrl #(.ROUNDS(2), .STAGES(1), .RCW(6)) u_dut_min (
        .clk(clk), .rst(rst), .start_i(start2), .done_ack_i(ack2),
        .busy_o(busy2), .done_o(done2), .sel_load_o(sel_load2),
        .en_state_o(en_state2), .stage_o(stage2), .round_end_o(round_end2),
        .last_round_o(last_round2), .round_cnt_o(round_cnt2), .rc_o(rc2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    typedef struct {
        int         rnd;
        logic [5:0] rc;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [5:0] rc_step(input logic [5:0] r);
        return {r[4:0], r[5] ^ r[4] ^ 1'b1};
    endfunction

    task automatic push_expected(input int rounds);
        logic [5:0] r;
        r = 6'h00;
        for (int i = 1; i <= rounds; i++) begin
            r = rc_step(r);
            sb_q.push_back('{i, r});
        end
    endtask

    function automatic logic [19:0] outs1();
        return {busy, done, sel_load, en_state, stage, round_end, last_round, round_cnt, rc};
    endfunction

    function automatic logic [18:0] outs2();
        return {busy2, done2, sel_load2, en_state2, stage2, round_end2, last_round2, round_cnt2, rc2};
    endfunction

    int e0;

    // Called at a negedge: request a run and return at the negedge after the
    // accepting edge (the LOAD cycle).
    task automatic start_run();
        start = 1'b1;
        push_expected(R);
        @(posedge clk);
        @(negedge clk);
        e0    = cyc;
        start = 1'b0;
    endtask

    // Called in the LOAD cycle; returns at the first negedge with done high.
    task automatic monitor_run(input bit pulse);
        int   k;
        int   nbusy, nen, nlr;
        bit   got_done;
        exp_t e;
        nbusy = 0; nen = 0; nlr = 0; got_done = 1'b0;
        for (k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            if (pulse) start = (k == 10 || k == 60);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (k == 0) check_val("load_sel", sel_load, 1);
            if (k == 1) check_val("run_sel", sel_load, 0);
            nbusy += int'(busy);
            nen   += int'(en_state);
            nlr   += int'(last_round);
            if (busy && !sel_load && round_end) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_extra_round", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check_val("round_cnt", round_cnt, e.rnd);
                    check_val("rc", rc, e.rc);
                    check_val("stage_at_end", stage, S - 1);
                    check_val("en_at_end", en_state, 1);
                    if (round_cnt == 6'd6)  check_val("rc_r6", rc, 32'h3E);
                    if (round_cnt == 6'd32) check_val("rc_r32", rc, 32'h38);
                end
            end
        end
        start = 1'b0;
        check_val("done_seen", got_done, 1);
        check_val("latency", k, 1 + R * S);
        check_val("busy_cycles", nbusy, 1 + R * S);
        check_val("en_pulses", nen, 1 + R);
        check_val("last_round_cycles", nlr, S);
        check_val("busy_in_done", busy, 0);
        check_val("sb_left", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int   nhold;
        bit   found;
        int   k2, nre2;
        exp_t e;
        logic [5:0] r;

        // Reset with start held high.
        rst = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_outs", outs1(), 0);
        check_val("rst_outs_min", outs2(), 0);
        push_expected(R);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e0    = cyc;
        start = 1'b0;
        monitor_run(1'b0);

        // DONE held without acknowledge.
        nhold = 0;
        repeat (20) begin
            @(negedge clk);
            if (done && !en_state && !busy) nhold++;
        end
        check_val("done_hold", nhold, 20);

        // Ack together with start: only the ack is taken.
        ack = 1'b1; start = 1'b1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        check_val("ack_done_clr", done, 0);
        check_val("ack_no_load", {busy, sel_load}, 0);

        // Second run with stray start pulses mid-run.
        start_run();
        monitor_run(1'b1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Reset in round 17, stage 2.
        start_run();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (round_cnt == 6'd17 && stage == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check_val("reach_r17", found, 1);
        #2 rst = 1'b1;
        #1 check_val("async_clr", outs1(), 0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        start_run();
        monitor_run(1'b0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Single-stage, two-round instance.
        r = 6'h00;
        for (int i = 1; i <= 2; i++) begin
            r = rc_step(r);
            sb_q.push_back('{i, r});
        end
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        check_val("min_load", {sel_load2, en_state2, busy2}, 3'b111);
        nre2 = 0;
        for (k2 = 1; k2 < 20; k2++) begin
            @(negedge clk);
            if (done2) break;
            if (round_end2) begin
                nre2++;
                if (sb_q.size() == 0) begin
                    check_val("min_sb_extra", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check_val("min_round", round_cnt2, e.rnd);
                    check_val("min_rc", rc2, e.rc);
                    check_val("min_stage", stage2, 0);
                    check_val("min_en", en_state2, 1);
                    check_val("min_last", last_round2, (e.rnd == 2) ? 1 : 0);
                end
            end
        end
        check_val("min_latency", k2, 3);
        check_val("min_round_ends", nre2, 2);
        check_val("min_sb_left", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
